// File: rtl/sprite_blit_ctrl.sv
// Purpose: sequencer for the 2bpp 128x64 vram write port; XOR sprite DRAW with collision, full-screen CLEAR.
// Latency: DRAW 2*bytes + columns + written_pixels + 1 cycles accept->done; CLEAR 8194 cycles.
// Backpressure: cmd_ready high only in IDLE; cmd_valid at any other time is dropped (no queue).
module sprite_blit_ctrl #(
  parameter int HBITS = 7,
  parameter int VBITS = 6,
  parameter int ABITS = 12,
  parameter int WRAP  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [HBITS-1:0] cmd_x,
  input  logic [VBITS-1:0] cmd_y,
  input  logic [3:0]       cmd_n,
  input  logic [ABITS-1:0] cmd_addr,
  input  logic [1:0]       cmd_plane,
  output logic [ABITS-1:0] mem_addr,
  output logic             mem_rd,
  input  logic [7:0]       mem_data,
  output logic [HBITS-1:0] vram_hpos,
  output logic [VBITS-1:0] vram_vpos,
  output logic [1:0]       vram_pixi,
  input  logic [1:0]       vram_pixo,
  output logic             vram_we,
  output logic             busy,
  output logic             done,
  output logic             collision
);

  localparam int CBITS = HBITS + VBITS;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_FETCH_WAIT, S_PIX_READ, S_PIX_WRITE, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [HBITS-1:0] x_q, x_d;
  logic [VBITS-1:0] y_q, y_d;
  logic [3:0]       n_q, n_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [1:0]       plane_q, plane_d;
  logic [4:0]       row_q, row_d, col_q, col_d;
  logic             byte_q, byte_d;
  logic [15:0]      bits_q, bits_d;
  logic [CBITS:0]   clr_q, clr_d;

  logic [HBITS-1:0] hpos_d;
  logic [VBITS-1:0] vpos_d;
  logic [ABITS-1:0] mem_addr_d;
  logic             we_d, mem_rd_d, collision_d, advance;

  logic             wide, clipped, pix_bit;
  logic [4:0]       row_last, col_last, row_inc, col_inc;
  logic [HBITS:0]   hsum;
  logic [VBITS:0]   vsum;

  // n==0 selects the 16x16 sprite: two bytes per row, sixteen rows
  assign wide     = (n_q == 4'd0);
  assign row_last = wide ? 5'd15 : ({1'b0, n_q} - 5'd1);
  assign col_last = wide ? 5'd15 : 5'd7;
  assign row_inc  = row_q + 5'd1;
  assign col_inc  = col_q + 5'd1;
  // Carry-out of the extended sum flags a pixel past the right/bottom edge
  assign hsum     = {1'b0, x_q} + (HBITS+1)'(col_q);
  assign vsum     = {1'b0, y_q} + (VBITS+1)'(row_q);
  assign clipped  = (WRAP == 0) && (hsum[HBITS] || vsum[VBITS]);
  // Leftmost pixel is the MSB; the row's bits sit left-justified in bits_q
  assign pix_bit  = bits_q[~col_q[3:0]];

  // Write data follows the registered read-back in the same cycle the write is issued
  assign vram_pixi = (state_q == S_PIX_WRITE) ? (vram_pixo ^ plane_q) : 2'b00;

  // Next-state and next-output decode; every output except vram_pixi is registered from here
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    n_d         = n_q;
    addr_d      = addr_q;
    plane_d     = plane_q;
    row_d       = row_q;
    col_d       = col_q;
    byte_d      = byte_q;
    bits_d      = bits_q;
    clr_d       = clr_q;
    hpos_d      = vram_hpos;
    vpos_d      = vram_vpos;
    mem_addr_d  = mem_addr;
    we_d        = 1'b0;
    mem_rd_d    = 1'b0;
    collision_d = collision;
    advance     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          x_d         = cmd_x;
          y_d         = cmd_y;
          n_d         = cmd_n;
          addr_d      = cmd_addr;
          plane_d     = cmd_plane;
          collision_d = 1'b0;
          if (cmd_op) begin
            state_d = S_CLEAR;
            clr_d   = '0;
          end else begin
            state_d    = S_FETCH;
            row_d      = '0;
            byte_d     = 1'b0;
            mem_rd_d   = 1'b1;
            mem_addr_d = cmd_addr;
          end
        end
      end
      S_CLEAR: begin
        // First CLEAR cycle primes the address register; writes trail the counter by one
        if (clr_q[CBITS]) begin
          state_d = S_DONE;
        end else begin
          we_d             = 1'b1;
          {hpos_d, vpos_d} = clr_q[CBITS-1:0];
          clr_d            = clr_q + 1'b1;
        end
      end
      S_FETCH: state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        if (wide && byte_q) bits_d[7:0]  = mem_data;
        else                bits_d[15:8] = mem_data;
        if (wide && !byte_q) begin
          byte_d     = 1'b1;
          state_d    = S_FETCH;
          mem_rd_d   = 1'b1;
          mem_addr_d = addr_q + ABITS'({row_q, 1'b1});
        end else begin
          state_d = S_PIX_READ;
          col_d   = '0;
          hpos_d  = x_q;
          vpos_d  = y_q + VBITS'(row_q);
        end
      end
      S_PIX_READ: begin
        if (pix_bit && !clipped) begin
          state_d = S_PIX_WRITE;
          we_d    = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      S_PIX_WRITE: begin
        if ((vram_pixo & plane_q) != 2'b00) collision_d = 1'b1;
        advance = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      if (col_q != col_last) begin
        col_d   = col_inc;
        hpos_d  = x_q + HBITS'(col_inc);
        state_d = S_PIX_READ;
      end else if (row_q != row_last) begin
        row_d      = row_inc;
        byte_d     = 1'b0;
        state_d    = S_FETCH;
        mem_rd_d   = 1'b1;
        mem_addr_d = addr_q + (wide ? ABITS'({row_inc, 1'b0}) : ABITS'(row_inc));
      end else begin
        state_d = S_DONE;
      end
    end
  end

  // State, command latches and registered outputs; synchronous reset drops vram_we on the next edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      n_q       <= '0;
      addr_q    <= '0;
      plane_q   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      byte_q    <= 1'b0;
      bits_q    <= '0;
      clr_q     <= '0;
      vram_hpos <= '0;
      vram_vpos <= '0;
      mem_addr  <= '0;
      vram_we   <= 1'b0;
      mem_rd    <= 1'b0;
      collision <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      n_q       <= n_d;
      addr_q    <= addr_d;
      plane_q   <= plane_d;
      row_q     <= row_d;
      col_q     <= col_d;
      byte_q    <= byte_d;
      bits_q    <= bits_d;
      clr_q     <= clr_d;
      vram_hpos <= hpos_d;
      vram_vpos <= vpos_d;
      mem_addr  <= mem_addr_d;
      vram_we   <= we_d;
      mem_rd    <= mem_rd_d;
      collision <= collision_d;
      cmd_ready <= (state_d == S_IDLE);
      busy      <= (state_d != S_IDLE) && (state_d != S_DONE);
      done      <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_sprite_blit_ctrl.sv
// Bench for sprite_blit_ctrl: emulates vram and program memory, predicts every vram write,
// every sprite fetch, latency and collision from the drawing rules, and checks them each cycle.
module tb_sprite_blit_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, cmd_valid, cmd_ready, cmd_op;
  logic [6:0]  cmd_x;
  logic [5:0]  cmd_y;
  logic [3:0]  cmd_n;
  logic [11:0] cmd_addr, mem_addr;
  logic [1:0]  cmd_plane, vram_pixi, vram_pixo;
  logic        mem_rd, vram_we, busy, done, collision;
  logic [7:0]  mem_data;
  logic [6:0]  vram_hpos;
  logic [5:0]  vram_vpos;

  always #5 clk = ~clk;

  sprite_blit_ctrl #(.HBITS(7), .VBITS(6), .ABITS(12), .WRAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n),
    .cmd_addr(cmd_addr), .cmd_plane(cmd_plane), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_data(mem_data), .vram_hpos(vram_hpos),
    .vram_vpos(vram_vpos), .vram_pixi(vram_pixi), .vram_pixo(vram_pixo),
    .vram_we(vram_we), .busy(busy), .done(done), .collision(collision)
  );

  logic [1:0]  ram  [8192];   // device contents
  logic [1:0]  mv   [8192];   // model's picture of the screen
  logic [7:0]  prog [4096];
  logic [14:0] wq[$];         // expected writes {addr, data}
  logic [11:0] rq[$];         // expected fetch addresses
  logic [14:0] cmp_e;
  logic [11:0] cmp_a;
  int total = 0, bad = 0, cyc = 0;
  int acc_cyc = 0, n_wr = 0, n_rd = 0, last_lat = 0, last_wr = 0, last_rd = 0, exp_lat = 0;
  logic exp_coll = 1'b0, held_coll = 1'b0;

  // vram with registered read port, program memory with one-cycle read
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (vram_we) ram[{vram_hpos, vram_vpos}] <= vram_pixi;
    vram_pixo <= ram[{vram_hpos, vram_vpos}];
    if (mem_rd) mem_data <= prog[mem_addr];
  end

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Compare process: checks status, writes, fetches, latency and collision against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      wq.delete();
      rq.delete();
      held_coll <= 1'b0;
    end else begin
      chk("status_onehot", int'(cmd_ready) + int'(busy) + int'(done), 1);
      if (cmd_ready) chk("collision_hold", int'(collision), int'(held_coll));
      if (vram_we) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          cmp_e = wq.pop_front();
          chk("vram_write", int'({vram_hpos, vram_vpos, vram_pixi}), int'(cmp_e));
        end
        n_wr <= n_wr + 1;
      end
      if (mem_rd) begin
        if (rq.size() == 0) chk("unexpected_fetch", 1, 0);
        else begin
          cmp_a = rq.pop_front();
          chk("mem_addr", int'(mem_addr), int'(cmp_a));
        end
        n_rd <= n_rd + 1;
      end
      if (cmd_valid && cmd_ready) begin
        acc_cyc <= cyc;
        n_wr    <= 0;
        n_rd    <= 0;
      end
      if (done) begin
        chk("latency", cyc - acc_cyc, exp_lat);
        chk("collision", int'(collision), int'(exp_coll));
        chk("queues_drained", wq.size() + rq.size(), 0);
        last_lat  <= cyc - acc_cyc;
        last_wr   <= n_wr;
        last_rd   <= n_rd;
        held_coll <= exp_coll;
      end
    end
  end

  task automatic model_clear(input bit upd);
    for (int a = 0; a < 8192; a++) begin
      if (upd) mv[a] = 2'b00;
      wq.push_back({13'(a), 2'b00});
    end
    exp_lat  = 8194;
    exp_coll = 1'b0;
  endtask

  task automatic model_draw(input int x, input int y, input int n, input int addr, input int plane);
    int rows, nb, cols, writes, px, py, a;
    logic [7:0] bv;
    logic [1:0] nv;
    rows = (n == 0) ? 16 : n;
    nb   = (n == 0) ? 2 : 1;
    cols = 8 * nb;
    writes = 0;
    exp_coll = 1'b0;
    for (int r = 0; r < rows; r++) begin
      for (int b = 0; b < nb; b++) rq.push_back(12'((addr + r * nb + b) % 4096));
      for (int c = 0; c < cols; c++) begin
        bv = prog[(addr + r * nb + c / 8) % 4096];
        px = x + c;
        py = y + r;
        if (bv[7 - (c % 8)] && px < 128 && py < 64) begin
          a  = px * 64 + py;
          if ((mv[a] & 2'(plane)) != 2'b00) exp_coll = 1'b1;
          nv = mv[a] ^ 2'(plane);
          mv[a] = nv;
          wq.push_back({13'(a), nv});
          writes++;
        end
      end
    end
    exp_lat = 2 * rows * nb + rows * cols + writes + 1;
  endtask

  task automatic issue(input bit op, input int x, input int y, input int n, input int addr, input int plane);
    @(posedge clk); #1;
    cmd_op = op; cmd_x = 7'(x); cmd_y = 6'(y); cmd_n = 4'(n);
    cmd_addr = 12'(addr); cmd_plane = 2'(plane); cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    bit seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_ram(string nm);
    int diff = 0;
    for (int a = 0; a < 8192; a++) if (ram[a] !== mv[a]) diff++;
    chk(nm, diff, 0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_x = '0; cmd_y = '0;
    cmd_n = '0; cmd_addr = '0; cmd_plane = '0;
    for (int a = 0; a < 8192; a++) mv[a] = 2'b00;
    for (int a = 0; a < 4096; a++) prog[a] = 8'h00;
    prog[12'h010] = 8'h80;
    prog[12'h100] = 8'hFF; prog[12'h101] = 8'hFF;
    for (int a = 0; a < 32; a++) prog[12'h200 + a] = 8'hFF;
    prog[12'h300] = 8'h3C;
    prog[12'h400] = 8'hA5; prog[12'h401] = 8'h5A; prog[12'h402] = 8'hFF;
    repeat (3) @(posedge clk); #1;
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_collision", int'(collision), 0);
    chk("rst_vram_we", int'(vram_we), 0);
    chk("rst_mem_rd", int'(mem_rd), 0);
    chk("rst_addrs", int'({vram_hpos, vram_vpos, vram_pixi, mem_addr}), 0);
    rst_n = 1'b1;

    // 1: full CLEAR
    model_clear(1'b1); issue(1'b1, 0, 0, 0, 0, 0); wait_done(9000);
    chk("t1_latency", last_lat, 8194); chk("t1_writes", last_wr, 8192); chk_ram("t1_ram");

    // 2: single pixel at origin
    model_draw(0, 0, 1, 12'h010, 1); issue(1'b0, 0, 0, 1, 12'h010, 1); wait_done(100);
    chk("t2_latency", last_lat, 12); chk("t2_pixel", int'(ram[0]), 1);
    chk("t2_collision", int'(collision), 0);

    // 3: same again erases it and collides
    model_draw(0, 0, 1, 12'h010, 1); issue(1'b0, 0, 0, 1, 12'h010, 1); wait_done(100);
    chk("t3_pixel", int'(ram[0]), 0); chk("t3_collision", int'(collision), 1);

    // 4: bottom-right corner clipping
    model_draw(124, 63, 2, 12'h100, 2); issue(1'b0, 124, 63, 2, 12'h100, 2); wait_done(200);
    chk("t4_writes", last_wr, 4); chk("t4_latency", last_lat, 25);
    chk("t4_collision", int'(collision), 0); chk_ram("t4_ram");

    // 5: 16x16 sprite
    model_draw(8, 8, 0, 12'h200, 3); issue(1'b0, 8, 8, 0, 12'h200, 3); wait_done(1000);
    chk("t5_writes", last_wr, 256); chk("t5_reads", last_rd, 32);
    chk("t5_latency", last_lat, 577); chk_ram("t5_ram");

    // 7: partial overlap with the 16x16 block collides
    model_draw(10, 8, 1, 12'h300, 1); issue(1'b0, 10, 8, 1, 12'h300, 1); wait_done(100);
    chk("t7_collision", int'(collision), 1); chk("t7_pixel", int'(ram[12 * 64 + 8]), 2);

    // 8: plane 0 leaves the screen and collision alone, timing unchanged
    model_draw(30, 20, 3, 12'h400, 0); issue(1'b0, 30, 20, 3, 12'h400, 0); wait_done(200);
    chk("t8_latency", last_lat, 47); chk("t8_collision", int'(collision), 0); chk_ram("t8_ram");

    // 6: stray command while busy, then reset in the middle of CLEAR
    model_clear(1'b0); issue(1'b1, 0, 0, 0, 0, 0);
    repeat (48) @(posedge clk); #1;
    chk("t6_busy", int'(busy), 1);
    cmd_op = 1'b0; cmd_n = 4'd1; cmd_addr = 12'h010; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (50) @(posedge clk); #1;
    chk("t6_we_before", int'(vram_we), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_we_after", int'(vram_we), 0);
    chk("t6_ready_after", int'(cmd_ready), 1);
    chk("t6_busy_after", int'(busy), 0);
    rst_n = 1'b1;
    chk_ram("t6_ram");

    // recovery after reset
    model_draw(0, 0, 1, 12'h010, 2); issue(1'b0, 0, 0, 1, 12'h010, 2); wait_done(100);
    chk("t9_pixel", int'(ram[0]), 2); chk("t9_latency", last_lat, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
